// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage feeding decode.
// Registers the combinational ROM word with its PC; handles redirects, stall and halt.
module fetch_unit #(
    parameter int                    ADDR_W     = 8,
    parameter int                    INSTR_W    = 9,
    parameter logic [ADDR_W-1:0]     RESET_PC   = 8'd0,
    parameter logic [INSTR_W-1:0]    HALT_INSTR = 9'b0111_00_010,
    parameter int                    CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_off,
    input  logic               jump_taken,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_valid;
    logic               r_halted;
    logic [CNT_W-1:0]   r_count;

    logic               w_jump;
    logic               w_branch;
    logic               w_halt;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_br_target;

    // Redirects only mean something for a live instruction in instr_q.
    assign w_jump      = r_valid & jump_taken;
    assign w_branch    = r_valid & branch_taken & ~jump_taken;
    assign w_halt      = r_valid & (r_instr == HALT_INSTR);
    assign w_accept    = r_valid & ~jump_taken & ~branch_taken;
    assign w_br_target = r_instr_pc + branch_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state  <= S_RUN;
                        r_pc     <= RESET_PC;
                        r_count  <= '0;
                        r_halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (w_accept) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (w_jump) begin
                            r_pc    <= jump_target;
                            r_valid <= 1'b0;
                        end else if (w_branch) begin
                            r_pc    <= w_br_target;
                            r_valid <= 1'b0;
                        end else if (w_halt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                            r_valid  <= 1'b0;
                        end else begin
                            r_instr    <= rom_instr;
                            r_instr_pc <= r_pc;
                            r_valid    <= 1'b1;
                            r_pc       <= r_pc + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = r_pc;
    assign instr_q     = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirects, stall, halt, restart, reset.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_off;
    logic       jump_taken;
    logic [7:0] jump_target;
    logic [7:0] rom_addr;
    logic [8:0] rom_instr;
    logic [8:0] instr_q;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       halted;
    logic [15:0] instr_count;

    logic [8:0] rom [256];
    int n_chk = 0;
    int n_err = 0;

    localparam logic [8:0] HALT = 9'b0111_00_010;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_off(branch_off),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .rom_addr(rom_addr), .rom_instr(rom_instr),
        .instr_q(instr_q), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    assign rom_instr = rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [7:0] pc);
        int n;
        n = 0;
        while (!(instr_valid && instr_pc == pc) && n < 400) begin
            tick();
            n++;
        end
        chk("run_to", {24'd0, instr_pc}, {24'd0, pc});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'h100 | 9'(i);
        rom[19] = HALT;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_off = '0;
        jump_taken = 1'b0; jump_target = '0;
        tick();
        tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_q", instr_q, 0);
        chk("rst_ipc", instr_pc, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", instr_valid, 0);

        // Run 1: straight line, branch, jump, stall, halt
        do_start();
        chk("st_valid", instr_valid, 0);
        chk("st_addr", rom_addr, 0);
        jump_taken = 1'b1; jump_target = 8'd50;
        tick();
        jump_taken = 1'b0;
        chk("noval_redir", instr_pc, 0);
        chk("f0_valid", instr_valid, 1);
        chk("f0_q", instr_q, 9'h100);
        chk("f0_addr", rom_addr, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("seq_pc", instr_pc, i);
            chk("seq_valid", instr_valid, 1);
            chk("seq_cnt", instr_count, i);
        end
        run_to(8'd10);
        branch_taken = 1'b1; branch_off = 8'd2;
        tick();
        branch_taken = 1'b0;
        chk("br_bubble", instr_valid, 0);
        chk("br_addr", rom_addr, 12);
        tick();
        chk("br_pc", instr_pc, 12);
        chk("br_valid", instr_valid, 1);
        run_to(8'd15);
        jump_taken = 1'b1; jump_target = 8'd8;
        branch_taken = 1'b1; branch_off = 8'd40;
        tick();
        jump_taken = 1'b0; branch_taken = 1'b0;
        chk("jmp_bubble", instr_valid, 0);
        chk("jmp_addr", rom_addr, 8);
        tick();
        chk("jmp_pc", instr_pc, 8);
        tick();
        chk("pre_stall", instr_pc, 9);
        stall = 1'b1;
        jump_taken = 1'b1; jump_target = 8'd77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", instr_pc, 9);
            chk("stall_addr", rom_addr, 10);
            chk("stall_valid", instr_valid, 1);
            chk("stall_cnt", instr_count, 10 + 3 + 1);
        end
        jump_taken = 1'b0;
        stall = 1'b0;
        tick();
        chk("resume_pc", instr_pc, 10);
        run_to(8'd19);
        chk("halt_q", instr_q, HALT);
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_valid", instr_valid, 0);
        chk("halt_cnt1", instr_count, 25);
        tick();
        tick();
        chk("halt_addr", rom_addr, 20);
        chk("halt_valid2", instr_valid, 0);

        // Run 2: restart from HALTED, negative branch wrap
        do_start();
        chk("rs_halted", halted, 0);
        chk("rs_cnt", instr_count, 0);
        chk("rs_addr", rom_addr, 0);
        tick();
        chk("rs_pc", instr_pc, 0);
        run_to(8'd2);
        branch_taken = 1'b1; branch_off = 8'hFD;
        tick();
        branch_taken = 1'b0;
        chk("neg_addr", rom_addr, 255);
        tick();
        chk("neg_pc", instr_pc, 255);
        tick();
        chk("wrap_pc", instr_pc, 0);
        run_to(8'd19);
        tick();
        chk("halt_cnt2", instr_count, 23);

        // Run 3: straight line to halt; start in RUN ignored
        do_start();
        run_to(8'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ign", instr_pc, 6);
        chk("start_ign_v", instr_valid, 1);
        run_to(8'd19);
        tick();
        chk("halt_flag3", halted, 1);
        chk("halt_cnt3", instr_count, 20);
        chk("halt_addr3", rom_addr, 20);

        // Run 4: reset mid-run beats branch
        do_start();
        run_to(8'd4);
        branch_taken = 1'b1; branch_off = 8'd5;
        rst_n = 1'b0;
        tick();
        chk("mr_valid", instr_valid, 0);
        chk("mr_addr", rom_addr, 0);
        chk("mr_q", instr_q, 0);
        chk("mr_ipc", instr_pc, 0);
        chk("mr_cnt", instr_count, 0);
        chk("mr_halted", halted, 0);
        rst_n = 1'b1; branch_taken = 1'b0;
        tick();
        tick();
        chk("mr_idle", instr_valid, 0);
        chk("mr_idle_a", rom_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
